// File: rtl/cic_link_monitor.sv
// CIC link monitor: compares local/peer CIC bit streams, counts errors, detects a stalled
// link and sequences host reset/start. Optional DEAD recovery via CIC_LINK_MONITOR_RECOVER_EN.
module cic_link_monitor #(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned WARMUP_BITS    = 16,
    parameter int unsigned ERR_LIMIT      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_i,
    input  logic                bit_strobe_i,
    input  logic [CHANNELS-1:0] chan_en_i,
    input  logic [CHANNELS-1:0] stream_local_i,
    input  logic [CHANNELS-1:0] stream_peer_i,
    output logic                dead_o,
    output logic                rst_host_o,
    output logic                start_o,
    output logic [1:0]          state_o,
    output logic [CNT_W-1:0]    bit_count_o,
    output logic [CNT_W-1:0]    err_count_o
);

    localparam int unsigned WU_W = (WARMUP_BITS < 1) ? 1 : $clog2(WARMUP_BITS + 1);
    localparam int unsigned TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_DEAD   = 2'd3
    } state_t;

    state_t            state_q;
    logic              dead_q;
    logic              rst_host_q;
    logic              start_q;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [WU_W-1:0]   wu_cnt_q, wu_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              mismatch_c;
    logic              err_dead_c;
    logic              wu_done_c;
    logic              timeout_c;
`ifdef CIC_LINK_MONITOR_RECOVER_EN
    logic [2:0]        ok_cnt_q;
`endif

    // Saturating counter increments and per-cycle decision terms
    assign bit_cnt_d  = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
    assign err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
    assign wu_cnt_d   = wu_cnt_q + WU_W'(1);
    assign to_cnt_d   = to_cnt_q + TO_W'(1);
    assign mismatch_c = |((stream_local_i ^ stream_peer_i) & chan_en_i);
    assign err_dead_c = (err_cnt_d >= CNT_W'(ERR_LIMIT));
    assign wu_done_c  = (wu_cnt_d == WU_W'(WARMUP_BITS));
    assign timeout_c  = (to_cnt_d >= TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dead_q     <= 1'b0;
            rst_host_q <= 1'b1;
            start_q    <= 1'b0;
            bit_cnt_q  <= '0;
            err_cnt_q  <= '0;
            wu_cnt_q   <= '0;
            to_cnt_q   <= '0;
`ifdef CIC_LINK_MONITOR_RECOVER_EN
            ok_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    bit_cnt_q <= '0;
                    err_cnt_q <= '0;
                    wu_cnt_q  <= '0;
                    to_cnt_q  <= '0;
                    if (run_i) begin
                        state_q <= S_WARMUP;
                    end
                end
                S_WARMUP: begin
                    if (!run_i) begin
                        state_q   <= S_IDLE;
                        bit_cnt_q <= '0;
                        err_cnt_q <= '0;
                        wu_cnt_q  <= '0;
                    end else if (WARMUP_BITS == 0 || (bit_strobe_i && wu_done_c)) begin
                        state_q    <= S_RUN;
                        start_q    <= 1'b1;
                        rst_host_q <= 1'b0;
                        to_cnt_q   <= '0;
                        wu_cnt_q   <= '0;
                    end else if (bit_strobe_i) begin
                        wu_cnt_q <= wu_cnt_d;
                    end
                end
                S_RUN: begin
                    // Dropping run aborts the exchange ahead of any error or timeout
                    if (!run_i) begin
                        state_q    <= S_IDLE;
                        start_q    <= 1'b0;
                        rst_host_q <= 1'b1;
                        bit_cnt_q  <= '0;
                        err_cnt_q  <= '0;
                        to_cnt_q   <= '0;
                    end else if (bit_strobe_i) begin
                        bit_cnt_q <= bit_cnt_d;
                        to_cnt_q  <= '0;
                        if (mismatch_c) begin
                            err_cnt_q <= err_cnt_d;
                            if (err_dead_c) begin
                                state_q    <= S_DEAD;
                                dead_q     <= 1'b1;
                                start_q    <= 1'b0;
                                rst_host_q <= 1'b1;
`ifdef CIC_LINK_MONITOR_RECOVER_EN
                                ok_cnt_q   <= '0;
`endif
                            end
                        end
                    end else begin
                        to_cnt_q <= to_cnt_d;
                        if (timeout_c) begin
                            state_q    <= S_DEAD;
                            dead_q     <= 1'b1;
                            start_q    <= 1'b0;
                            rst_host_q <= 1'b1;
`ifdef CIC_LINK_MONITOR_RECOVER_EN
                            ok_cnt_q   <= '0;
`endif
                        end
                    end
                end
                S_DEAD: begin
`ifdef CIC_LINK_MONITOR_RECOVER_EN
                    // Eight clean strobes in a row re-arm the link through WARMUP
                    if (bit_strobe_i) begin
                        if (mismatch_c) begin
                            ok_cnt_q <= '0;
                        end else if (ok_cnt_q == 3'd7) begin
                            state_q   <= S_WARMUP;
                            dead_q    <= 1'b0;
                            err_cnt_q <= '0;
                            wu_cnt_q  <= '0;
                            ok_cnt_q  <= '0;
                        end else begin
                            ok_cnt_q <= ok_cnt_q + 3'd1;
                        end
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state_o     = state_q;
    assign dead_o      = dead_q;
    assign rst_host_o  = rst_host_q;
    assign start_o     = start_q;
    assign bit_count_o = bit_cnt_q;
    assign err_count_o = err_cnt_q;

endmodule
